// File: rtl/sp_ram_be_pipe.sv
// Single-port synchronous RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register, read-valid strobe and post-reset clear sequencer.
module sp_ram_be_pipe #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned RD_MODE      = 0,
    parameter int unsigned OUT_REG      = 0,
    parameter int unsigned CLEAR_ON_RST = 1,
    localparam int unsigned AW          = $clog2(DEPTH),
    localparam int unsigned NB          = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w_en,
    input  logic [NB-1:0]    be,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             busy
);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_e;

    localparam state_e        RST_STATE = (CLEAR_ON_RST != 0) ? S_CLEAR : S_IDLE;
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             in_range;
    logic             rd_req;
    logic             wr_req;
    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] merged_word;

    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_vld_q, s1_vld_d;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                end
            end
            S_IDLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign busy = (state_q == S_CLEAR);

    // ------------------------------------------------------------------
    // Request decode and byte-lane merge
    // ------------------------------------------------------------------
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign rd_req   = en && !busy && !w_en;
    assign wr_req   = en && !busy && w_en;
    assign old_word = in_range ? mem_q[addr] : '0;

    always_comb begin
        merged_word = old_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Storage has no reset; the sequencer owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_req && in_range) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: read data capture with read-during-write policy
    // ------------------------------------------------------------------
    always_comb begin
        s1_data_d = s1_data_q;
        s1_vld_d  = 1'b0;
        if (rd_req) begin
            s1_data_d = old_word;
            s1_vld_d  = 1'b1;
        end else if (wr_req) begin
            case (RD_MODE)
                0: begin
                    s1_data_d = old_word;
                    s1_vld_d  = 1'b1;
                end
                1: begin
                    // A dropped out-of-range write reports zero, like a read would.
                    s1_data_d = in_range ? merged_word : '0;
                    s1_vld_d  = 1'b1;
                end
                default: begin
                    s1_data_d = s1_data_q;
                    s1_vld_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stage 2
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] s2_data_q, s2_data_d;
        logic             s2_vld_q;

        always_comb begin
            s2_data_d = s2_data_q;
            if (s1_vld_q) begin
                s2_data_d = s1_data_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_data_q <= '0;
                s2_vld_q  <= 1'b0;
            end else begin
                s2_data_q <= s2_data_d;
                s2_vld_q  <= s1_vld_q;
            end
        end

        assign data_out = s2_data_q;
        assign rd_valid = s2_vld_q;
    end else begin : g_no_out_reg
        assign data_out = s1_data_q;
        assign rd_valid = s1_vld_q;
    end

endmodule

// File: tb/tb_sp_ram_be_pipe.sv
// Scoreboard bench for sp_ram_be_pipe: three configurations share one stimulus stream,
// each with its own reference memory and expected-output queue.
module tb_sp_ram_be_pipe;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              w_en;
    logic [3:0]        be;
    logic [3:0]        addr;
    logic [31:0]       din;
    logic [2:0][31:0]  dout;
    logic [2:0]        rv;
    logic [2:0]        bsy;

    int unsigned edge_n = 0;
    int          vectors = 0;
    int          miscompares = 0;

    int unsigned dep  [3] = '{16, 16, 10};
    int unsigned lat  [3] = '{1, 2, 1};
    int unsigned mode [3] = '{0, 1, 2};

    logic [31:0] mdl [3][16];
    logic [31:0] last_out [3];
    exp_t        sbq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    sp_ram_be_pipe #(.DEPTH(16), .WIDTH(32), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .w_en(w_en), .be(be), .addr(addr), .data_in(din),
        .data_out(dout[0]), .rd_valid(rv[0]), .busy(bsy[0]));

    sp_ram_be_pipe #(.DEPTH(16), .WIDTH(32), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .w_en(w_en), .be(be), .addr(addr), .data_in(din),
        .data_out(dout[1]), .rd_valid(rv[1]), .busy(bsy[1]));

    sp_ram_be_pipe #(.DEPTH(10), .WIDTH(32), .RD_MODE(2), .OUT_REG(0), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .w_en(w_en), .be(be), .addr(addr), .data_in(din),
        .data_out(dout[2]), .rd_valid(rv[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic sample();
        logic exp_v;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            exp_v = (sbq[k].size() != 0) && (sbq[k][0].due == edge_n);
            check($sformatf("u%0d.rd_valid", k), 32'(rv[k]), 32'(exp_v));
            if (exp_v) begin
                e = sbq[k].pop_front();
                check($sformatf("u%0d.data", k), dout[k], e.data);
                last_out[k] = e.data;
            end else begin
                check($sformatf("u%0d.hold", k), dout[k], last_out[k]);
            end
        end
    endtask

    task automatic step(input logic e, input logic w, input logic [3:0] b,
                        input logic [3:0] a, input logic [31:0] d);
        logic        inr;
        logic [31:0] old;
        logic [31:0] mg;
        en = e; w_en = w; be = b; addr = a; din = d;
        for (int k = 0; k < 3; k++) begin
            inr = (32'(a) < dep[k]);
            old = inr ? mdl[k][a] : 32'h0;
            if (e && !w) begin
                sbq[k].push_back('{edge_n + lat[k], old});
            end else if (e && w) begin
                mg = old;
                for (int i = 0; i < 4; i++) if (b[i]) mg[8*i +: 8] = d[8*i +: 8];
                if (inr) mdl[k][a] = mg;
                if (mode[k] == 0) sbq[k].push_back('{edge_n + lat[k], old});
                else if (mode[k] == 1) sbq[k].push_back('{edge_n + lat[k], inr ? mg : 32'h0});
            end
        end
        @(posedge clk);
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset(input int abort_after);
        int cnt [3];
        en = 1'b0; w_en = 1'b0; be = 4'h0; addr = 4'h0; din = 32'h0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            last_out[k] = 32'h0;
            cnt[k] = 0;
            for (int j = 0; j < 16; j++) mdl[k][j] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.rst_data", k), dout[k], 32'h0);
            check($sformatf("u%0d.rst_valid", k), 32'(rv[k]), 32'h0);
            check($sformatf("u%0d.rst_busy", k), 32'(bsy[k]), 32'h1);
        end
        rst = 1'b0;
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                check($sformatf("u%0d.midclr_busy", k), 32'(bsy[k]), 32'h1);
            rst = 1'b0;
        end
        // Writes during the clear must be ignored; stop them before the shortest clear ends.
        en = 1'b1; w_en = 1'b1; be = 4'hF; addr = 4'h1; din = 32'hDEADBEEF;
        #1;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 3; k++) if (bsy[k]) cnt[k]++;
            if (bsy == 3'b000) break;
            if (t == 10) en = 1'b0;
            @(negedge clk);
            sample();
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++)
            check($sformatf("u%0d.busy_cycles", k), 32'(cnt[k]), dep[k]);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; w_en = 1'b0; be = 4'h0; addr = 4'h0; din = 32'h0;

        // Reset clear then full readback
        do_reset(0);
        for (int a = 0; a < 16; a++) step(1, 0, 4'h0, 4'(a), 32'h0);

        // Byte-lane writes
        step(1, 1, 4'hF, 4'd3, 32'hA5A5A5A5);
        step(1, 1, 4'h5, 4'd3, 32'h11223344);
        step(1, 0, 4'h0, 4'd3, 32'h0);
        check("be_model", mdl[0][3], 32'hA522A544);

        // Read-during-write policies, including an all-lanes-off write
        step(1, 1, 4'hF, 4'd2, 32'h0000FFFF);
        step(0, 0, 4'h0, 4'd0, 32'h0);
        step(1, 1, 4'hF, 4'd2, 32'h12345678);
        step(0, 0, 4'h0, 4'd0, 32'h0);
        step(1, 1, 4'h0, 4'd2, 32'hFFFFFFFF);
        step(1, 0, 4'h0, 4'd2, 32'h0);
        step(0, 0, 4'h0, 4'd0, 32'h0);

        // Preload and back-to-back reads
        for (int a = 0; a < 8; a++) step(1, 1, 4'hF, 4'(a), 32'(a * 32'h11));
        for (int a = 0; a < 8; a++) step(1, 0, 4'h0, 4'(a), 32'h0);
        step(1, 1, 4'hF, 4'd9, 32'h0BADF00D);
        step(1, 0, 4'h0, 4'd9, 32'h0);
        step(0, 0, 4'h0, 4'd0, 32'h0);

        // Out-of-range access on the 10-deep instance
        step(1, 1, 4'hF, 4'd12, 32'hCAFEBABE);
        step(1, 0, 4'h0, 4'd12, 32'h0);
        for (int a = 0; a < 10; a++) step(1, 0, 4'h0, 4'(a), 32'h0);
        step(1, 1, 4'h3, 4'd13, 32'h5A5A5A5A);
        step(1, 0, 4'h0, 4'd13, 32'h0);

        // Reset in the middle of the clear sequence
        do_reset(5);
        for (int a = 0; a < 16; a++) step(1, 0, 4'h0, 4'(a), 32'h0);

        repeat (3) step(0, 0, 4'h0, 4'd0, 32'h0);
        check("sb_empty", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
